// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG TAP register slice.
// Opcodes are given at 5 bits and zero-extended (or truncated) to IR_W where used.
package jtag_pkg;

    localparam int         IR_W_DEF   = 5;

    localparam logic [4:0] OP_IDCODE  = 5'h01;
    localparam logic [4:0] OP_BYPASS  = 5'h1F;
    localparam logic [4:0] OP_USER    = 5'h10;

    // IR capture pattern: low two bits 2'b01, upper bits zero
    localparam logic [1:0] IR_CAP_LSB = 2'b01;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

endpackage

// File: rtl/jtag_dr_shift.sv
// Generic capture/shift/update data register clocked by tck.
// Priority capture > shift > update. sr[0] is the serial output bit.
// clr_n is the controller's synchronous Test-Logic-Reset indication.
module jtag_dr_shift #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         tck,
    input  logic         trst,
    input  logic         clr_n,
    input  logic         cap,
    input  logic         shift,
    input  logic         upd,
    input  logic [W-1:0] din,
    input  logic         tdi,
    output logic         so,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr_q, sr_d;
    logic [W-1:0] dout_q, dout_d;

    // next-state: load parallel data, shift LSB-first, or publish shadow
    always_comb begin
        sr_d   = sr_q;
        dout_d = dout_q;
        if (cap)        sr_d   = din;
        else if (shift) sr_d   = {tdi, sr_q[W-1:1]};
        else if (upd)   dout_d = sr_q;
    end

    // state registers, async trst and sync controller reset
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            sr_q   <= RST_VAL;
            dout_q <= '0;
        end else if (!clr_n) begin
            sr_q   <= RST_VAL;
            dout_q <= '0;
        end else begin
            sr_q   <= sr_d;
            dout_q <= dout_d;
        end
    end

    assign so   = sr_q[0];
    assign dout = dout_q;

endmodule

// File: rtl/jtag_tap_regs.sv
// IR, DR bank and TDO retiming behind an IEEE 1149.1 TAP controller.
// Optional USER data register enabled by defining JTAG_USERDR_EN.
module jtag_tap_regs
    import jtag_pkg::*;
#(
    parameter int          IR_W       = IR_W_DEF,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_5FC5,
    parameter int          USER_W     = 32
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tdi,
    input  logic              reset,
    input  logic              shiftIR,
    input  logic              captureIR,
    input  logic              updateIR,
    input  logic              shiftDR,
    input  logic              captureDR,
    input  logic              updateDR,
    input  logic              select,
    input  logic              tdo_en,
    output logic [IR_W-1:0]   instr,
    input  logic [USER_W-1:0] user_din,
    output logic [USER_W-1:0] user_dout,
    output logic              user_upd,
    output logic              tdo,
    output logic              tdo_oe
);

    localparam logic [IR_W-1:0] IR_CAP   = IR_W'(IR_CAP_LSB);
    localparam logic [IR_W-1:0] OPC_IDC  = IR_W'(OP_IDCODE);

    logic [IR_W-1:0] ir_shift_q, ir_shift_d;
    logic [IR_W-1:0] instr_q, instr_d;
    logic            bypass_q, bypass_d;
    logic            tdo_q, tdo_oe_q;
    dr_sel_t         dr_sel;
    logic            dr_bit;
    logic            idcode_so;
    logic [31:0]     idcode_dout_unused;

    // IR next-state: capture pattern, LSB-first shift, or commit to instr
    always_comb begin
        ir_shift_d = ir_shift_q;
        instr_d    = instr_q;
        if (captureIR)     ir_shift_d = IR_CAP;
        else if (shiftIR)  ir_shift_d = {tdi, ir_shift_q[IR_W-1:1]};
        else if (updateIR) instr_d    = ir_shift_q;
    end

    // IR registers; reset lands on IDCODE so a mid-scan abort restores it
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_shift_q <= '0;
            instr_q    <= OPC_IDC;
        end else if (!reset) begin
            ir_shift_q <= '0;
            instr_q    <= OPC_IDC;
        end else begin
            ir_shift_q <= ir_shift_d;
            instr_q    <= instr_d;
        end
    end

    // instruction decode; unknown opcodes fall back to BYPASS
    always_comb begin
        dr_sel = DR_BYPASS;
        if (instr_q == OPC_IDC) dr_sel = DR_IDCODE;
`ifdef JTAG_USERDR_EN
        else if (instr_q == IR_W'(OP_USER)) dr_sel = DR_USER;
`endif
    end

    // BYPASS next-state: captures 0, otherwise a one-bit tdi delay
    always_comb begin
        bypass_d = bypass_q;
        if (dr_sel == DR_BYPASS) begin
            if (captureDR)    bypass_d = 1'b0;
            else if (shiftDR) bypass_d = tdi;
        end
    end

    // BYPASS register
    always_ff @(posedge tck or negedge trst) begin
        if (!trst)       bypass_q <= 1'b0;
        else if (!reset) bypass_q <= 1'b0;
        else             bypass_q <= bypass_d;
    end

    jtag_dr_shift #(
        .W       (32),
        .RST_VAL (IDCODE_VAL)
    ) u_idcode (
        .tck   (tck),
        .trst  (trst),
        .clr_n (reset),
        .cap   (captureDR && dr_sel == DR_IDCODE),
        .shift (shiftDR && dr_sel == DR_IDCODE),
        .upd   (1'b0),
        .din   (IDCODE_VAL),
        .tdi   (tdi),
        .so    (idcode_so),
        .dout  (idcode_dout_unused)
    );

`ifdef JTAG_USERDR_EN
    logic              user_so;
    logic              user_upd_q, user_upd_d;

    jtag_dr_shift #(
        .W       (USER_W),
        .RST_VAL ('0)
    ) u_user (
        .tck   (tck),
        .trst  (trst),
        .clr_n (reset),
        .cap   (captureDR && dr_sel == DR_USER),
        .shift (shiftDR && dr_sel == DR_USER),
        .upd   (updateDR && dr_sel == DR_USER),
        .din   (user_din),
        .tdi   (tdi),
        .so    (user_so),
        .dout  (user_dout)
    );

    // update pulse only when the update actually wins over capture/shift
    always_comb begin
        user_upd_d = updateDR && !captureDR && !shiftDR && (dr_sel == DR_USER);
    end

    // one-tck registered update strobe
    always_ff @(posedge tck or negedge trst) begin
        if (!trst)       user_upd_q <= 1'b0;
        else if (!reset) user_upd_q <= 1'b0;
        else             user_upd_q <= user_upd_d;
    end

    assign user_upd = user_upd_q;
`else
    logic unused_user_inputs;
    logic user_so;

    assign unused_user_inputs = ^{user_din, updateDR};
    assign user_so            = 1'b0;
    assign user_dout          = '0;
    assign user_upd           = 1'b0;
`endif

    // serial bit from whichever DR the instruction selects
    always_comb begin
        case (dr_sel)
            DR_IDCODE: dr_bit = idcode_so;
            DR_USER:   dr_bit = user_so;
            default:   dr_bit = bypass_q;
        endcase
    end

    // TDO retimed to the falling edge so it is stable at the next rising edge
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else if (!reset) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= select ? ir_shift_q[0] : dr_bit;
            tdo_oe_q <= tdo_en;
        end
    end

    assign instr  = instr_q;
    assign tdo    = tdo_q;
    assign tdo_oe = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_regs.sv
// Bench for jtag_tap_regs: bit-queue reference model, per-edge compare,
// directed scans with literal expectations, then randomized strobes.
// Define JTAG_USERDR_EN to exercise the USER data register.
module tb_jtag_tap_regs;

    localparam int          IR_W   = 5;
    localparam int          USER_W = 32;
    localparam logic [31:0] IDV    = 32'h1000_5FC5;

    // strobe encodings {cIR,sIR,uIR,cDR,sDR,uDR}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] CIR  = 6'b100000;
    localparam logic [5:0] SIR  = 6'b010000;
    localparam logic [5:0] UIR  = 6'b001000;
    localparam logic [5:0] CDR  = 6'b000100;
    localparam logic [5:0] SDR  = 6'b000010;
    localparam logic [5:0] UDR  = 6'b000001;

    logic tck = 1'b0, trst = 1'b0, tdi = 1'b0, reset = 1'b1;
    logic shiftIR = 1'b0, captureIR = 1'b0, updateIR = 1'b0;
    logic shiftDR = 1'b0, captureDR = 1'b0, updateDR = 1'b0;
    logic select = 1'b0, tdo_en = 1'b0;
    logic [USER_W-1:0] user_din = '0;
    logic [IR_W-1:0]   instr;
    logic [USER_W-1:0] user_dout;
    logic              user_upd, tdo, tdo_oe;

    int checks = 0;
    int failures = 0;

    jtag_tap_regs dut (
        .tck(tck), .trst(trst), .tdi(tdi), .reset(reset),
        .shiftIR(shiftIR), .captureIR(captureIR), .updateIR(updateIR),
        .shiftDR(shiftDR), .captureDR(captureDR), .updateDR(updateDR),
        .select(select), .tdo_en(tdo_en), .instr(instr),
        .user_din(user_din), .user_dout(user_dout), .user_upd(user_upd),
        .tdo(tdo), .tdo_oe(tdo_oe)
    );

    always #5 tck = ~tck;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: registers as bit queues, [0] = LSB/out ----------------
    typedef bit bq_t[$];
    bq_t q_ir, q_by, q_id, q_us;
    logic [IR_W-1:0]   m_instr;
    logic [USER_W-1:0] m_dout;
    logic              m_upd;
    logic              e_tdo, e_oe;

    function automatic bq_t bits_of(input logic [63:0] v, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[i]);
        return q;
    endfunction

    function automatic logic [63:0] word_of(input bq_t q);
        logic [63:0] w = '0;
        foreach (q[i]) w[i] = q[i];
        return w;
    endfunction

    // 0 = bypass, 1 = idcode, 2 = user
    function automatic int dsel(input logic [IR_W-1:0] ins);
        if (ins == 5'h01) return 1;
`ifdef JTAG_USERDR_EN
        if (ins == 5'h10) return 2;
`endif
        return 0;
    endfunction

    function automatic void m_reset();
        q_ir    = bits_of(64'd0, IR_W);
        m_instr = 5'h01;
        q_by    = bits_of(64'd0, 1);
        q_id    = bits_of({32'd0, IDV}, 32);
        q_us    = bits_of(64'd0, USER_W);
        m_dout  = '0;
        m_upd   = 1'b0;
    endfunction

    always @(posedge tck or negedge trst) begin : model_pos
        int s;
        if (!trst || !reset) m_reset();
        else begin
            s = dsel(m_instr);
            if (captureIR) q_ir = bits_of(64'd1, IR_W);
            else if (shiftIR) begin q_ir.push_back(tdi); void'(q_ir.pop_front()); end
            else if (updateIR) m_instr = IR_W'(word_of(q_ir));
            m_upd = 1'b0;
            if (captureDR) begin
                if (s == 1)      q_id = bits_of({32'd0, IDV}, 32);
                else if (s == 2) q_us = bits_of({32'd0, user_din}, USER_W);
                else             q_by = bits_of(64'd0, 1);
            end else if (shiftDR) begin
                if (s == 1)      begin q_id.push_back(tdi); void'(q_id.pop_front()); end
                else if (s == 2) begin q_us.push_back(tdi); void'(q_us.pop_front()); end
                else             begin q_by.push_back(tdi); void'(q_by.pop_front()); end
            end else if (updateDR && s == 2) begin
                m_dout = USER_W'(word_of(q_us));
                m_upd  = 1'b1;
            end
        end
    end

    always @(negedge tck or negedge trst) begin : model_neg
        int s;
        if (!trst || !reset) begin
            e_tdo = 1'b0;
            e_oe  = 1'b0;
        end else begin
            s = dsel(m_instr);
            if (select)      e_tdo = q_ir[0];
            else if (s == 1) e_tdo = q_id[0];
            else if (s == 2) e_tdo = q_us[0];
            else             e_tdo = q_by[0];
            e_oe = tdo_en;
        end
    end

    // single compare process: parallel outputs after rise, serial outputs after fall
    initial begin
        forever begin
            @(tck);
            #1;
            if (trst === 1'b1) begin
                if (tck) begin
                    chk("instr", 64'(instr), 64'(m_instr));
                    chk("user_dout", 64'(user_dout), 64'(m_dout));
                    chk("user_upd", 64'(user_upd), 64'(m_upd));
                end else begin
                    chk("tdo", 64'(tdo), 64'(e_tdo));
                    chk("tdo_oe", 64'(tdo_oe), 64'(e_oe));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // drive one tck cycle (inputs set just after the falling edge), return tdo after the next fall
    task automatic cyc(input logic [5:0] s, input logic sel, input logic d, output logic o);
        {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR} = s;
        select = sel;
        tdi    = d;
        tdo_en = s[4] | s[1];
        @(posedge tck);
        @(negedge tck);
        #1;
        o = tdo;
    endtask

    task automatic scan_ir(input logic [IR_W-1:0] v);
        logic o;
        cyc(CIR, 1'b1, 1'b0, o);
        for (int i = 0; i < IR_W; i++) cyc(SIR, 1'b1, v[i], o);
        cyc(UIR, 1'b1, 1'b0, o);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic        o;
        logic [31:0] w;
        logic [4:0]  e;
        logic [3:0]  p;
        logic [3:0]  c;
        logic [31:0] val;
        logic [4:0]  opt [5];

        // reset state while trst held low
        @(negedge tck); @(negedge tck); #1;
        chk("rst_instr", 64'(instr), 64'h01);
        chk("rst_tdo", 64'(tdo), 64'h0);
        chk("rst_tdo_oe", 64'(tdo_oe), 64'h0);
        chk("rst_user_dout", 64'(user_dout), 64'h0);
        chk("rst_user_upd", 64'(user_upd), 64'h0);
        trst = 1'b1;

        // IDCODE straight out of reset, then zeros shifted in behind it
        cyc(NONE, 1'b0, 1'b0, o);
        w[0] = o;
        for (int i = 1; i < 32; i++) begin cyc(SDR, 1'b0, 1'b0, o); w[i] = o; end
        chk("idcode_scan", 64'(w), 64'h1000_5FC5);
        cyc(SDR, 1'b0, 1'b0, o);
        chk("idcode_tail", 64'(o), 64'h0);

        // IR capture pattern out LSB first, instr untouched
        cyc(CIR, 1'b1, 1'b0, o);
        e[0] = o;
        for (int i = 1; i < 5; i++) begin cyc(SIR, 1'b1, 1'b0, o); e[i] = o; end
        chk("ir_capture", 64'(e), 64'h01);
        chk("instr_hold", 64'(instr), 64'h01);

        // BYPASS one-bit delay
        scan_ir(5'h1F);
        chk("instr_bypass", 64'(instr), 64'h1F);
        p = 4'b1101;
        cyc(CDR, 1'b0, 1'b0, o);
        e[0] = o;
        for (int i = 0; i < 4; i++) begin cyc(SDR, 1'b0, p[i], o); e[i+1] = o; end
        chk("bypass_seq", 64'(e), 64'h1A);

        // undefined opcode behaves as BYPASS (bypass currently holds 1)
        scan_ir(5'h07);
        cyc(CDR, 1'b0, 1'b0, o);
        c[0] = o;
        cyc(SDR, 1'b0, 1'b1, o); c[1] = o;
        cyc(SDR, 1'b0, 1'b1, o); c[2] = o;
        cyc(SDR, 1'b0, 1'b0, o); c[3] = o;
        chk("undef_bypass", 64'(c), 64'h6);

        // trst mid-ShiftIR restores IDCODE immediately
        scan_ir(5'h1F);
        cyc(CIR, 1'b1, 1'b0, o);
        cyc(SIR, 1'b1, 1'b1, o);
        cyc(SIR, 1'b1, 1'b1, o);
        #2 trst = 1'b0;
        #1;
        chk("trst_instr", 64'(instr), 64'h01);
        chk("trst_tdo", 64'(tdo), 64'h0);
        chk("trst_tdo_oe", 64'(tdo_oe), 64'h0);
        @(negedge tck); #1;
        trst = 1'b1;
        cyc(CDR, 1'b0, 1'b0, o);
        w[0] = o;
        for (int i = 1; i < 32; i++) begin cyc(SDR, 1'b0, 1'b1, o); w[i] = o; end
        chk("trst_idcode", 64'(w), 64'h1000_5FC5);

        // synchronous controller reset
        scan_ir(5'h1F);
        reset = 1'b0;
        cyc(NONE, 1'b1, 1'b0, o);
        reset = 1'b1;
        chk("sreset_instr", 64'(instr), 64'h01);
        chk("sreset_tdo", 64'(o), 64'h0);

`ifdef JTAG_USERDR_EN
        scan_ir(5'h10);
        user_din = 32'hDEAD_BEEF;
        val = 32'h1234_5678;
        cyc(CDR, 1'b0, 1'b0, o);
        w[0] = o;
        for (int i = 0; i < 32; i++) begin
            cyc(SDR, 1'b0, val[i], o);
            if (i < 31) w[i+1] = o;
        end
        chk("user_capture", 64'(w), 64'hDEAD_BEEF);
        cyc(UDR, 1'b0, 1'b0, o);
        chk("user_upd_hi", 64'(user_upd), 64'h1);
        chk("user_dout", 64'(user_dout), 64'h1234_5678);
        cyc(NONE, 1'b0, 1'b0, o);
        chk("user_upd_lo", 64'(user_upd), 64'h0);
`else
        scan_ir(5'h10);
        user_din = 32'hDEAD_BEEF;
        cyc(CDR, 1'b0, 1'b0, o);
        chk("user_as_bypass_cap", 64'(o), 64'h0);
        cyc(SDR, 1'b0, 1'b1, o);
        chk("user_as_bypass_sh", 64'(o), 64'h1);
        cyc(UDR, 1'b0, 1'b0, o);
        chk("user_dout_tied", 64'(user_dout), 64'h0);
`endif

        // randomized strobes, including overlapping ones, against the model
        opt[0] = 5'h01; opt[1] = 5'h1F; opt[2] = 5'h10; opt[3] = 5'h07; opt[4] = 5'h00;
        for (int blk = 0; blk < 60; blk++) begin
            logic [4:0] op;
            op = opt[$urandom_range(0, 4)];
            if (op == 5'h00) op = 5'($urandom);
            scan_ir(op);
            for (int k = 0; k < 30; k++) begin
                logic [5:0] s;
                if ($urandom_range(0, 3) == 0) s = 6'($urandom);
                else begin
                    case ($urandom_range(0, 5))
                        0:       s = CDR;
                        1:       s = UDR;
                        default: s = SDR;
                    endcase
                end
                user_din = $urandom;
                reset    = ($urandom_range(0, 99) != 0);
                cyc(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
            end
            reset = 1'b1;
        end

        cyc(NONE, 1'b0, 1'b0, o);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
